// File: rtl/decoder_stage_if.sv
// Decoder-stage bus: instruction in, registered decode fields and control flags out.
// The imm member exists only when DECODER_IMM_EN is defined.
interface decoder_stage_if;
    logic [31:0] instruction;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        jump_reg;
`ifdef DECODER_IMM_EN
    logic [31:0] imm;
`endif

    modport master (
`ifdef DECODER_IMM_EN
        input  imm,
`endif
        output instruction,
        input  rs1_addr, rs2_addr, rd_addr, alu_op,
        input  reg_write, alu_src, mem_read, mem_write,
        input  mem_to_reg, branch, jump, jump_reg
    );

    modport slave (
`ifdef DECODER_IMM_EN
        output imm,
`endif
        input  instruction,
        output rs1_addr, rs2_addr, rd_addr, alu_op,
        output reg_write, alu_src, mem_read, mem_write,
        output mem_to_reg, branch, jump, jump_reg
    );
endinterface

// File: rtl/decoder_stage.sv
// RV32I decode stage: combinational decode, every output registered (1-cycle latency).
// Optional macro DECODER_IMM_EN adds the registered sign-extended immediate.
module decoder_stage (
    input  logic            clk,
    input  logic            rst,
    decoder_stage_if.slave  dec
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
        logic jump_reg;
    } ctrl_t;

    logic [XLEN-1:0]   instr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              alt;
    logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;

    assign instr  = dec.instruction;
    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign alt    = instr[30];

    // funct3 -> ALU op; alt (funct7[5]) picks SUB only when allowed, SRA always.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt_i,
                                            input logic sub_ok);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (alt_i && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_i ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    ctrl_t             ctrl_d, ctrl_q;
    alu_op_e           alu_op_d, alu_op_q;
    logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

    always_comb begin
        ctrl_d   = '0;
        alu_op_d = ALU_ADD;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        case (opcode)
            OPC_R: begin
                ctrl_d.reg_write = 1'b1;
                alu_op_d = alu_from_f3(funct3, alt, 1'b1);
                rs1_d = rs1_f;
                rs2_d = rs2_f;
                rd_d  = rd_f;
            end
            OPC_I_ALU: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                alu_op_d = alu_from_f3(funct3, alt, 1'b0);
                rs1_d = rs1_f;
                rd_d  = rd_f;
            end
            OPC_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                rs1_d = rs1_f;
                rd_d  = rd_f;
            end
            OPC_STORE: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                rs1_d = rs1_f;
                rs2_d = rs2_f;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1;
                alu_op_d = ALU_SUB;
                rs1_d = rs1_f;
                rs2_d = rs2_f;
            end
            OPC_JAL: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                rd_d = rd_f;
            end
            OPC_JALR: begin
                ctrl_d.jump_reg  = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                rs1_d = rs1_f;
                rd_d  = rd_f;
            end
            OPC_LUI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                alu_op_d = ALU_PASS_B;
                rd_d = rd_f;
            end
            OPC_AUIPC: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                rd_d = rd_f;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            alu_op_q <= ALU_ADD;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
        end
    end

    assign dec.rs1_addr   = rs1_q;
    assign dec.rs2_addr   = rs2_q;
    assign dec.rd_addr    = rd_q;
    assign dec.alu_op     = alu_op_q;
    assign dec.reg_write  = ctrl_q.reg_write;
    assign dec.alu_src    = ctrl_q.alu_src;
    assign dec.mem_read   = ctrl_q.mem_read;
    assign dec.mem_write  = ctrl_q.mem_write;
    assign dec.mem_to_reg = ctrl_q.mem_to_reg;
    assign dec.branch     = ctrl_q.branch;
    assign dec.jump       = ctrl_q.jump;
    assign dec.jump_reg   = ctrl_q.jump_reg;

`ifdef DECODER_IMM_EN
    logic [XLEN-1:0] imm_d, imm_q;

    // Immediate format follows the opcode class; R-type and bubbles carry zero.
    always_comb begin
        imm_d = '0;
        case (opcode)
            OPC_I_ALU, OPC_LOAD, OPC_JALR:
                imm_d = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_JAL:
                imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_d = {instr[31:12], 12'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) imm_q <= '0;
        else     imm_q <= imm_d;
    end

    assign dec.imm = imm_q;
`else
    // Without the immediate path these instruction bits feed nothing.
    logic unused_imm_bits;
    assign unused_imm_bits = ^{instr[31], instr[29:25]};
`endif

endmodule

// File: tb/tb_decoder_stage.sv
// Table-driven bench for decoder_stage; checks imm too when DECODER_IMM_EN is defined.
module tb_decoder_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    decoder_stage_if dec ();

    decoder_stage dut (
        .clk (clk),
        .rst (rst),
        .dec (dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [7:0]  flags;  // reg_write alu_src mem_read mem_write mem_to_reg branch jump jump_reg
        logic [31:0] imm;
    } vec_t;

    localparam int unsigned NVEC = 16;
    vec_t vecs [NVEC];
    vec_t zero_v;

    int checks = 0;
    int errors = 0;

    task automatic check_outputs(input string name, input vec_t e);
        logic [26:0] act, expv;
        act  = {dec.rs1_addr, dec.rs2_addr, dec.rd_addr, dec.alu_op,
                dec.reg_write, dec.alu_src, dec.mem_read, dec.mem_write,
                dec.mem_to_reg, dec.branch, dec.jump, dec.jump_reg};
        expv = {e.rs1, e.rs2, e.rd, e.alu, e.flags};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: {rs1,rs2,rd,alu,flags} actual=%07h required=%07h", name, act, expv);
        end
`ifdef DECODER_IMM_EN
        checks++;
        if (dec.imm !== e.imm) begin
            errors++;
            $display("FAIL %s imm: actual=%08h required=%08h", name, dec.imm, e.imm);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_v = '{"zero", 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 8'b0000_0000, 32'h0};
        vecs[0]  = '{"add",   32'h007302b3, 5'd6, 5'd7, 5'd5, 4'd0,  8'b1000_0000, 32'h0};
        vecs[1]  = '{"lw",    32'h0081a283, 5'd3, 5'd0, 5'd5, 4'd0,  8'b1110_1000, 32'd8};
        vecs[2]  = '{"sw",    32'h0040a623, 5'd1, 5'd4, 5'd0, 4'd0,  8'b0101_0000, 32'd12};
        vecs[3]  = '{"beq",   32'h00208263, 5'd1, 5'd2, 5'd0, 4'd1,  8'b0000_0100, 32'd4};
        vecs[4]  = '{"jal",   32'h008000ef, 5'd0, 5'd0, 5'd1, 4'd0,  8'b1000_0010, 32'd8};
        vecs[5]  = '{"addi",  32'hfff10093, 5'd2, 5'd0, 5'd1, 4'd0,  8'b1100_0000, 32'hffffffff};
        vecs[6]  = '{"jalr",  32'h006200e7, 5'd4, 5'd0, 5'd1, 4'd0,  8'b1100_0001, 32'd6};
        vecs[7]  = '{"lui",   32'h123453b7, 5'd0, 5'd0, 5'd7, 4'd10, 8'b1100_0000, 32'h12345000};
        vecs[8]  = '{"bubble",32'h00000000, 5'd0, 5'd0, 5'd0, 4'd0,  8'b0000_0000, 32'h0};
        vecs[9]  = '{"sub",   32'h402081b3, 5'd1, 5'd2, 5'd3, 4'd1,  8'b1000_0000, 32'h0};
        vecs[10] = '{"sra",   32'h4020d1b3, 5'd1, 5'd2, 5'd3, 4'd7,  8'b1000_0000, 32'h0};
        vecs[11] = '{"srai",  32'h4040d193, 5'd1, 5'd0, 5'd3, 4'd7,  8'b1100_0000, 32'h404};
        vecs[12] = '{"and",   32'h003170b3, 5'd2, 5'd3, 5'd1, 4'd9,  8'b1000_0000, 32'h0};
        vecs[13] = '{"sltiu", 32'h00513093, 5'd2, 5'd0, 5'd1, 4'd4,  8'b1100_0000, 32'd5};
        vecs[14] = '{"auipc", 32'h00001297, 5'd0, 5'd0, 5'd5, 4'd0,  8'b1100_0000, 32'h1000};
        vecs[15] = '{"badop", 32'hffffffff, 5'd0, 5'd0, 5'd0, 4'd0,  8'b0000_0000, 32'h0};

        // Reset held for two edges with a live R-type on the bus
        dec.instruction = vecs[0].instr;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_outputs("reset", zero_v);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("post_reset_add", vecs[0]);

        // Outputs must hold until the next edge even when the input changes
        dec.instruction = vecs[1].instr;
        #2;
        check_outputs("hold_between_edges", vecs[0]);

        for (int i = 1; i < int'(NVEC); i++) begin
            dec.instruction = vecs[i].instr;
            @(posedge clk); #1;
            check_outputs(vecs[i].name, vecs[i]);
        end

        // Bubble directly after a valid store
        dec.instruction = vecs[2].instr;
        @(posedge clk); #1;
        check_outputs("sw_before_bubble", vecs[2]);
        dec.instruction = 32'h0;
        @(posedge clk); #1;
        check_outputs("bubble_after_sw", zero_v);

        // Mid-stream reset discards the pending decode, release decodes normally
        dec.instruction = vecs[1].instr;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs("midstream_reset", zero_v);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("after_midstream_reset", vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
